// File: rtl/ff_array_pkg.sv
// Shared types and helpers for the flip-flop storage array.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ff_array_pkg;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_e;

  // Upper bounds for the mask expansion helper; callers size-cast the result.
  localparam int MAX_WIDTH = 512;
  localparam int MAX_LANES = 512;

  // Expand a per-lane write mask into a per-bit mask; lane l covers bits
  // [l*lane_w +: lane_w]. Bits beyond lane_w*num_lanes are left at zero.
  function automatic logic [MAX_WIDTH-1:0] lane_mask_expand(
    input logic [MAX_LANES-1:0] mask,
    input int                   lane_w,
    input int                   num_lanes
  );
    logic [MAX_WIDTH-1:0] bits;
    bits = '0;
    for (int b = 0; b < MAX_WIDTH; b++) begin
      if (b < lane_w * num_lanes) begin
        bits[b] = mask[b / lane_w];
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/ff_array_clr_seq.sv
// Clear sequencer: walks every set index once, one set per cycle.
// Latency: busy the edge after clr_req, then 2**S_INDEX cycles of sweep writes.
// Backpressure: none; clr_req while sweeping is ignored, no restart.
module ff_array_clr_seq
  import ff_array_pkg::*;
#(
  parameter int S_INDEX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               clr_we,
  output logic [S_INDEX-1:0] clr_addr
);

  clr_state_e         state, state_nxt;
  logic [S_INDEX-1:0] cnt, cnt_nxt;

  // State and sweep counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter returns to zero on the terminal set so it
  // never indexes past the last set.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      CLR_IDLE: begin
        if (clr_req) begin
          state_nxt = CLR_SWEEP;
          cnt_nxt   = '0;
        end
      end
      CLR_SWEEP: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + S_INDEX'(1);
        if (cnt == {S_INDEX{1'b1}}) begin
          state_nxt = CLR_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLR_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign clr_busy = (state == CLR_SWEEP);
  assign clr_addr = cnt;

endmodule

// File: rtl/ff_array_mp.sv
// Flip-flop set-state array: 1 RW port, NUM_RD read ports, lane-masked writes, bypass, sweep clear.
// Latency: reads combinational from the registered address; writes land one edge after capture.
// Backpressure: none; writes captured while a clear starts or is sweeping are silently dropped.
module ff_array_mp
  import ff_array_pkg::*;
#(
  parameter int               S_INDEX = 4,
  parameter int               WIDTH   = 32,
  parameter int               LANE_W  = 8,
  parameter int               NUM_RD  = 2,
  parameter int               BYPASS  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                              clk0,
  input  logic                              rst0_n,
  input  logic                              csb0,
  input  logic                              web0,
  input  logic [S_INDEX-1:0]                addr0,
  input  logic [WIDTH/LANE_W-1:0]           wmask0,
  input  logic [WIDTH-1:0]                  din0,
  output logic [WIDTH-1:0]                  dout0,
  input  logic [NUM_RD-1:0]                 csb1,
  input  logic [NUM_RD-1:0][S_INDEX-1:0]    addr1,
  output logic [NUM_RD-1:0][WIDTH-1:0]      dout1,
  input  logic                              clr_req,
  output logic                              clr_busy
);

  localparam int NUM_SETS  = 2 ** S_INDEX;
  localparam int NUM_LANES = WIDTH / LANE_W;

  logic [WIDTH-1:0]               mem [NUM_SETS];
  logic [S_INDEX-1:0]             addr0_q;
  logic [WIDTH-1:0]               din0_q;
  logic [NUM_LANES-1:0]           wmask0_q;
  logic                           web0_q;
  logic [NUM_RD-1:0][S_INDEX-1:0] addr1_q;

  logic                           clr_we;
  logic [S_INDEX-1:0]             clr_addr;
  logic                           clr_accept;
  logic                           clr_last;
  logic                           wr_block;
  logic                           wr_pend;
  logic [WIDTH-1:0]               bit_mask;
  logic [WIDTH-1:0]               cur0;
  logic [WIDTH-1:0]               merged0;

  ff_array_clr_seq #(
    .S_INDEX (S_INDEX)
  ) u_clr_seq (
    .clk      (clk0),
    .rst_n    (rst0_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A write may not commit on an edge that carries a sweep write. Writes
  // captured on the final sweep edge commit after the sweep, so they are let in.
  assign clr_accept = clr_req && !clr_busy;
  assign clr_last   = clr_we && (clr_addr == S_INDEX'(NUM_SETS - 1));
  assign wr_block   = clr_accept || (clr_busy && !clr_last);
  assign wr_pend    = !web0_q;

  assign bit_mask = WIDTH'(lane_mask_expand(MAX_LANES'(wmask0_q), LANE_W, NUM_LANES));
  assign cur0     = mem[addr0_q];
  assign merged0  = (din0_q & bit_mask) | (cur0 & ~bit_mask);
  assign dout0    = ((BYPASS != 0) && wr_pend) ? merged0 : cur0;

  // Port 0 capture: address/data/mask follow chip select, write enable is
  // forced inactive when deselected or when the clear owns the array.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      addr0_q  <= '0;
      din0_q   <= '0;
      wmask0_q <= '0;
      web0_q   <= 1'b1;
    end else if (!csb0) begin
      addr0_q  <= addr0;
      din0_q   <= din0;
      wmask0_q <= wmask0;
      web0_q   <= web0 | wr_block;
    end else begin
      web0_q   <= 1'b1;
    end
  end

  // Read-port address capture; each port holds its address while deselected.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      addr1_q <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (!csb1[k]) begin
          addr1_q[k] <= addr1[k];
        end
      end
    end
  end

  // Storage: sweep writes take the array first; pending port-0 writes commit
  // the merged word so unmasked lanes keep their contents.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        mem[i] <= RST_VAL;
      end
    end else if (clr_we) begin
      mem[clr_addr] <= RST_VAL;
    end else if (wr_pend) begin
      mem[addr0_q] <= merged0;
    end
  end

  // Read ports see the merged word only when they point at the pending set.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign dout1[k] = ((BYPASS != 0) && wr_pend && (addr1_q[k] == addr0_q))
                      ? merged0 : mem[addr1_q[k]];
  end

endmodule

// File: tb/tb_ff_array_mp.sv
// Directed bench for ff_array_mp: one BYPASS=1 and one BYPASS=0 instance on shared inputs.
// Latency: inputs driven 1ns after the rising edge, outputs compared right after.
// Backpressure: n/a.
module tb_ff_array_mp;

  logic             clk0;
  logic             rst0_n;
  logic             csb0;
  logic             web0;
  logic [3:0]       addr0;
  logic [3:0]       wmask0;
  logic [31:0]      din0;
  logic [1:0]       csb1;
  logic [1:0][3:0]  addr1;
  logic             clr_req;

  logic [31:0]      dout0_b, dout0_n;
  logic [1:0][31:0] dout1_b, dout1_n;
  logic             busy_b, busy_n;

  int n_chk  = 0;
  int n_pass = 0;

  ff_array_mp #(.S_INDEX(4), .WIDTH(32), .LANE_W(8), .NUM_RD(2), .BYPASS(1), .RST_VAL('0)) u_byp (
    .clk0(clk0), .rst0_n(rst0_n), .csb0(csb0), .web0(web0), .addr0(addr0),
    .wmask0(wmask0), .din0(din0), .dout0(dout0_b), .csb1(csb1), .addr1(addr1),
    .dout1(dout1_b), .clr_req(clr_req), .clr_busy(busy_b)
  );

  ff_array_mp #(.S_INDEX(4), .WIDTH(32), .LANE_W(8), .NUM_RD(2), .BYPASS(0), .RST_VAL('0)) u_nob (
    .clk0(clk0), .rst0_n(rst0_n), .csb0(csb0), .web0(web0), .addr0(addr0),
    .wmask0(wmask0), .din0(din0), .dout0(dout0_n), .csb1(csb1), .addr1(addr1),
    .dout1(dout1_n), .clr_req(clr_req), .clr_busy(busy_n)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic idle();
    csb0    = 1'b1;
    web0    = 1'b1;
    csb1    = 2'b11;
    clr_req = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0   = 1'b0;
    web0   = 1'b0;
    addr0  = a;
    din0   = d;
    wmask0 = m;
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  initial begin
    rst0_n = 1'b1;
    idle();
    addr0  = '0;
    din0   = '0;
    wmask0 = '0;
    addr1  = '0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst0_n = 1'b0;
    #1;
    chk("rst_dout0",     dout0_b,    32'h0);
    chk("rst_dout1_0",   dout1_b[0], 32'h0);
    chk("rst_dout1_1",   dout1_b[1], 32'h0);
    chk("rst_busy",      32'(busy_b), 32'h0);
    chk("rst_busy_nob",  32'(busy_n), 32'h0);
    @(negedge clk0) rst0_n = 1'b1;

    // Masked write: lanes 0 and 2 of AABBCCDD over 11223344.
    wr(4'd3, 32'h11223344, 4'hF);
    tick();
    wr(4'd3, 32'hAABBCCDD, 4'b0101);
    csb1[0]  = 1'b0;
    addr1[0] = 4'd3;
    tick();
    chk("mw_byp_dout0",  dout0_b,    32'h11BB33DD);
    chk("mw_byp_dout1",  dout1_b[0], 32'h11BB33DD);
    chk("mw_nob_dout0",  dout0_n,    32'h11223344);
    chk("mw_nob_dout1",  dout1_n[0], 32'h11223344);
    idle();
    tick();
    chk("mw_nob_dout1_next", dout1_n[0], 32'h11BB33DD);
    chk("mw_nob_dout0_next", dout0_n,    32'h11BB33DD);
    chk("mw_byp_dout1_next", dout1_b[0], 32'h11BB33DD);

    // Write then read of the same set on the following capture.
    wr(4'd7, 32'h01020304, 4'hF);
    tick();
    idle();
    csb1[1]  = 1'b0;
    addr1[1] = 4'd7;
    tick();
    chk("wr_rd_nob", dout1_n[1], 32'h01020304);
    chk("wr_rd_byp", dout1_b[1], 32'h01020304);

    // Fill sets 0..14, set 15 written the cycle before the clear request.
    for (int i = 0; i < 15; i++) begin
      wr(4'(i), 32'hFFFFFFFF, 4'hF);
      tick();
    end
    wr(4'd15, 32'h5A5A5A5A, 4'hF);
    tick();
    idle();
    clr_req  = 1'b1;
    csb1[1]  = 1'b0;
    addr1[1] = 4'd15;
    tick();
    chk("clr_busy_start", 32'(busy_b), 32'h1);
    chk("clr_pre_write",  dout1_n[1], 32'h5A5A5A5A);

    // Sweep: set i cleared at edge C+1+i, set i+1 still intact.
    for (int i = 0; i < 16; i++) begin
      idle();
      csb1     = 2'b00;
      addr1[0] = 4'(i);
      addr1[1] = 4'(i + 1);
      if (i == 4)  wr(4'd2, 32'h12345678, 4'hF);
      if (i == 6)  clr_req = 1'b1;
      if (i == 15) wr(4'd5, 32'hCAFEF00D, 4'hF);
      tick();
      chk($sformatf("sweep_busy_%0d", i), 32'(busy_n), (i < 15) ? 32'h1 : 32'h0);
      chk($sformatf("sweep_clr_%0d", i), dout1_n[0], 32'h0);
      if (i < 15)
        chk($sformatf("sweep_next_%0d", i), dout1_n[1],
            (i == 14) ? 32'h5A5A5A5A : 32'hFFFFFFFF);
    end
    chk("post_clr_wr_byp", dout0_b, 32'hCAFEF00D);
    chk("post_clr_wr_nob", dout0_n, 32'h0);
    idle();
    csb1     = 2'b00;
    addr1[0] = 4'd2;
    addr1[1] = 4'd5;
    tick();
    chk("busy_wr_dropped", dout1_n[0], 32'h0);
    chk("post_clr_commit", dout1_n[1], 32'hCAFEF00D);
    chk("post_clr_idle",   32'(busy_b), 32'h0);

    // Reset in the middle of a sweep.
    wr(4'd12, 32'h77777777, 4'hF);
    tick();
    idle();
    clr_req  = 1'b1;
    csb1[0]  = 1'b0;
    addr1[0] = 4'd12;
    tick();
    chk("rs_pre_val",  dout1_b[0], 32'h77777777);
    chk("rs_pre_busy", 32'(busy_b), 32'h1);
    idle();
    repeat (7) tick();
    #2 rst0_n = 1'b0;
    #1;
    chk("rs_busy",    32'(busy_b), 32'h0);
    chk("rs_busy_n",  32'(busy_n), 32'h0);
    chk("rs_dout0",   dout0_b,    32'h0);
    chk("rs_dout1_0", dout1_b[0], 32'h0);
    chk("rs_dout1_1", dout1_n[1], 32'h0);
    @(negedge clk0) rst0_n = 1'b1;
    wr(4'd12, 32'hDEADBEEF, 4'hF);
    csb1     = 2'b00;
    addr1[0] = 4'd12;
    addr1[1] = 4'd5;
    tick();
    chk("rs_set12_clr", dout1_n[0], 32'h0);
    chk("rs_set5_clr",  dout1_n[1], 32'h0);
    chk("rs_wr_byp",    dout1_b[0], 32'hDEADBEEF);
    idle();
    tick();
    chk("rs_wr_commit", dout1_n[0], 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
